line_scan_engine: RTL and testbench
===================================

# line_scan_engine

Parametrised memory-scan engine: on `start`, it walks a run of consecutive memory lines, classifies each word by sign and by equality with the previous word, and accumulates both counts. When writeback is compiled in, it also replaces negative words in place with their magnitude. It is the next-generation controller/datapath pair for the line-scanning flow: width, depth and start/length are now configurable, and it adds a start/done handshake, address wrap-around and writeback. It sits between the system sequencer and a single-port synchronous-read memory.

## Interface
- `DATA_W`, 16, word width (two's complement).
- `ADDR_W`, 6, memory address width; depth is 2^ADDR_W.
- `CNT_W`, ADDR_W+1, counter width; holds counts up to 2^ADDR_W.
---
- `clk` in 1: clock. Rising edge.
- `rst` in 1: reset. Asynchronous, active-high.
- `start` in 1: begin a scan. Sampled only in IDLE.
- `base` in ADDR_W: first line address. Captured when start is accepted.
- `len` in CNT_W: number of lines, 0..2^ADDR_W. Captured when start is accepted.
- `busy` out 1: high from start acceptance through the DONE cycle.
- `done` out 1: one-cycle pulse when a scan completes.
- `neg_cnt` out CNT_W: number of negative words in the last scan.
- `eq_cnt` out CNT_W: number of words equal to their predecessor in scan order.
- `mem_addr` out ADDR_W: memory address.
- `mem_read` out 1: read strobe. Data is valid on `mem_rdata` the following cycle.
- `mem_rdata` in DATA_W: read data.
- `mem_write` out 1: write strobe.
- `mem_wdata` out DATA_W: write data.

## Operation
- FSM states: IDLE, READ, EVAL, WRITE, DONE.
- IDLE:
  - On `start`: latch `ptr=base` and `rem=len`; clear `neg_cnt`, `eq_cnt` and `first`.
  - Go to DONE if `len==0`, otherwise go to READ.
- READ: drive `mem_read=1` with `mem_addr=ptr`; go to EVAL.
- EVAL (`mem_rdata` valid):
  - If the MSB is set, increment `neg_cnt`.
  - If the word is not the first word of the scan and equals `prev`, increment `eq_cnt`.
  - Set `prev=mem_rdata`.
  - If the word is negative and writeback is enabled, go to WRITE.
  - Otherwise, if `rem==1`, go to DONE.
  - Otherwise decrement `rem`, set `ptr=ptr+1`, and go to READ.
- WRITE:
  - Drive `mem_write=1`, `mem_addr=ptr` and `mem_wdata=-prev`.
  - The most-negative value (MSB-only) saturates to the maximum positive value.
  - Then apply the same rem/ptr step as EVAL and go to DONE or READ.
- DONE: `done=1`; go to IDLE.
- `ptr` increments modulo 2^ADDR_W, so address 2^ADDR_W-1 is followed by 0.
- Equality compares the original read value, not the written-back value.
- `start` is ignored while `busy=1`.
- `start` is accepted in IDLE in the cycle right after DONE.
- Counters do not overflow: count ≤ `len` ≤ 2^ADDR_W, which fits in CNT_W.
- `neg_cnt` and `eq_cnt` hold their values after `done` until the next accepted start.
- `mem_addr` holds its last value when no strobe is active.

## Timing
- Reset values: state IDLE, and every output 0 (`busy`, `done`, `neg_cnt`, `eq_cnt`, `mem_addr`, `mem_read`, `mem_write`, `mem_wdata`). Internal `ptr`, `rem` and `prev` also reset to 0.
- Cycle numbering: `start` is sampled high at edge k.
  - `busy` rises in cycle k+1.
  - First `mem_read` is in cycle k+1.
  - `done` occurs in cycle k+1+2·len+W, where W is the number of writebacks.
  - For `len==0`, `done` occurs in cycle k+1.
- Throughput: 2 cycles per line, plus 1 cycle per negative word when writeback is enabled.
- `mem_read` and `mem_write` are never asserted in the same cycle.
- `rst` asserted mid-scan:
  - Immediately returns the engine to IDLE and zeroes all outputs.
  - Memory contents already written are not restored.
  - A write strobe does not persist past reset assertion.

## Configuration
- Macro: `LINE_SCAN_WRITEBACK_EN`.
- Defined: the WRITE state exists and negative words are replaced in place by their (saturated) magnitude.
- Undefined:
  - WRITE is removed and `mem_write` and `mem_wdata` are tied to 0.
  - EVAL always proceeds directly to DONE or READ.
  - Cycle count is exactly 2·len.

## Structure
- Package `line_scan_pkg` holds:
  - The state enum `line_scan_state_t` (IDLE, READ, EVAL, WRITE, DONE).
  - Default width constants.
  - A saturating-negate function.
- Top `line_scan_engine` contains the FSM (the controller role).
- Sub-module `line_scan_datapath` holds `ptr`, `rem`, `prev`, `first`, both counters, the comparator and the negator. It is driven by load/step/count enables from the FSM and returns `last` (`rem==1`), `neg` and `eq` flags.

## Test plan
- Basic count:
  - Stimulus: base=0, len=4, memory {5, -3, -3, 7}, writeback off.
  - Required: `neg_cnt=2`, `eq_cnt=1`, `done` at cycle k+9, no writes.
- Empty scan:
  - Stimulus: len=0.
  - Required: `done` at cycle k+1, both counts 0, no memory strobes.
- Wrap-around:
  - Stimulus: ADDR_W=6, base=62, len=4.
  - Required: read addresses 62, 63, 0, 1 in order.
- Writeback (macro defined):
  - Stimulus: {-5, 16'h8000, 2}.
  - Required: memory becomes {5, 16'h7FFF, 2}, `neg_cnt=2`, `done` at cycle k+9.
- Busy and reset:
  - Stimulus: pulse `start` during a scan; then assert `rst` in the middle of the scan.
  - Required: the second `start` is ignored; after reset all outputs are 0 and the state is IDLE.
  - Required: a new scan accepted after reset counts from 0.

Source files
------------

// File: rtl/line_scan_pkg.sv
// Shared types, default widths and helpers for the line-scan engine.
package line_scan_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 6;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EVAL,
        WRITE,
        DONE
    } line_scan_state_t;

    // x is a w-bit value sign-extended to 64 bits; the most-negative value saturates.
    function automatic logic [63:0] sat_neg(input logic [63:0] x, input int unsigned w);
        logic [63:0] min_v;
        min_v = ~64'd0 << (w - 1);
        if (x == min_v) begin
            return ~min_v;
        end
        return -x;
    endfunction

endpackage

// File: rtl/line_scan_datapath.sv
// Scan datapath: address pointer, remaining count, previous word and the
// negative/equal counters, stepped by enables from the controller.
module line_scan_datapath
    import line_scan_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned CNT_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] base,
    input  logic [CNT_W-1:0]  len,
    input  logic              load,
    input  logic              step,
    input  logic              count,
    input  logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ptr,
    output logic [ADDR_W-1:0] ptr_nxt_c,
    output logic              last_c,
    output logic              neg_c,
    output logic [CNT_W-1:0]  neg_cnt,
    output logic [CNT_W-1:0]  eq_cnt
);

    logic [CNT_W-1:0]  rem;
    logic [DATA_W-1:0] prev;
    // first is clear until the first word of a scan has been evaluated
    logic              first;
    logic              eq_c;

    assign ptr_nxt_c = load ? base : (step ? ptr + ADDR_W'(1) : ptr);
    assign last_c    = (rem == CNT_W'(1));
    assign neg_c     = rdata[DATA_W-1];
    assign eq_c      = first && (rdata == prev);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= '0;
            rem     <= '0;
            prev    <= '0;
            first   <= 1'b0;
            neg_cnt <= '0;
            eq_cnt  <= '0;
        end else begin
            ptr <= ptr_nxt_c;
            if (load) begin
                rem     <= len;
                first   <= 1'b0;
                neg_cnt <= '0;
                eq_cnt  <= '0;
            end else begin
                if (step) begin
                    rem <= rem - CNT_W'(1);
                end
                if (count) begin
                    prev  <= rdata;
                    first <= 1'b1;
                    if (neg_c) begin
                        neg_cnt <= neg_cnt + CNT_W'(1);
                    end
                    if (eq_c) begin
                        eq_cnt <= eq_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/line_scan_engine.sv
// Line-scan controller: walks len lines from base, counting negative and repeated words.
// Define LINE_SCAN_WRITEBACK_EN to replace negative words in place with their magnitude.
module line_scan_engine
    import line_scan_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned CNT_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [CNT_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  neg_cnt,
    output logic [CNT_W-1:0]  eq_cnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata
);

`ifdef LINE_SCAN_WRITEBACK_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif

    line_scan_state_t  state, next_state;
    logic              load, step, count;
    logic              last_c, neg_c;
    logic [ADDR_W-1:0] ptr, ptr_nxt_c, addr_d;

    line_scan_datapath #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) u_datapath (
        .clk      (clk),
        .rst      (rst),
        .base     (base),
        .len      (len),
        .load     (load),
        .step     (step),
        .count    (count),
        .rdata    (mem_rdata),
        .ptr      (ptr),
        .ptr_nxt_c(ptr_nxt_c),
        .last_c   (last_c),
        .neg_c    (neg_c),
        .neg_cnt  (neg_cnt),
        .eq_cnt   (eq_cnt)
    );

`ifdef LINE_SCAN_WRITEBACK_EN
    logic [DATA_W-1:0] wdata_d;
`endif

    // Next state plus next values of the registered memory-side outputs
    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        count      = 1'b0;
        addr_d     = mem_addr;
`ifdef LINE_SCAN_WRITEBACK_EN
        wdata_d    = mem_wdata;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = (len == CNT_W'(0)) ? DONE : READ;
                end
            end
            READ: next_state = EVAL;
            EVAL: begin
                count = 1'b1;
                if (neg_c && WB_EN) begin
                    next_state = WRITE;
                end else if (last_c) begin
                    next_state = DONE;
                end else begin
                    step       = 1'b1;
                    next_state = READ;
                end
            end
`ifdef LINE_SCAN_WRITEBACK_EN
            WRITE: begin
                if (last_c) begin
                    next_state = DONE;
                end else begin
                    step       = 1'b1;
                    next_state = READ;
                end
            end
`endif
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase

        if (next_state == READ) begin
            addr_d = ptr_nxt_c;
        end else if (next_state == WRITE) begin
            addr_d = ptr;
        end
`ifdef LINE_SCAN_WRITEBACK_EN
        // Negated from the word being evaluated, which is also what prev latches
        if (next_state == WRITE) begin
            wdata_d = DATA_W'(sat_neg(64'($signed(mem_rdata)), DATA_W));
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_read <= 1'b0;
            mem_addr <= '0;
        end else begin
            state    <= next_state;
            busy     <= (next_state != IDLE);
            done     <= (next_state == DONE);
            mem_read <= (next_state == READ);
            mem_addr <= addr_d;
        end
    end

`ifdef LINE_SCAN_WRITEBACK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_write <= 1'b0;
            mem_wdata <= '0;
        end else begin
            mem_write <= (next_state == WRITE);
            mem_wdata <= wdata_d;
        end
    end
`else
    assign mem_write = 1'b0;
    assign mem_wdata = '0;
`endif

endmodule

// File: tb/tb_line_scan_engine.sv
// Self-checking bench for line_scan_engine against a word-level scan model.
module tb_line_scan_engine;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned CNT_W  = 7;
    localparam int          DEPTH  = 64;
    localparam int          BUDGET = 400;

    logic              clk, rst, start;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  len;
    logic              busy, done, mem_read, mem_write;
    logic [CNT_W-1:0]  neg_cnt, eq_cnt;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata, mem_wdata;

    logic [DATA_W-1:0] mem     [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic              pl_en;
    logic [ADDR_W-1:0] pl_addr;
    logic [DATA_W-1:0] pl_data;

    int checks = 0;
    int errors = 0;

    int obs_done, obs_writes;
    bit obs_overlap, obs_busy1;
    int obs_reads[$];
    int exp_neg, exp_eq, exp_done, exp_writes;
    int exp_reads[$];

    line_scan_engine #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base     (base),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .neg_cnt  (neg_cnt),
        .eq_cnt   (eq_cnt),
        .mem_addr (mem_addr),
        .mem_read (mem_read),
        .mem_rdata(mem_rdata),
        .mem_write(mem_write),
        .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous-read memory, with a bench-side preload port
    always @(posedge clk) begin
        if (mem_read) mem_rdata <= mem[mem_addr];
        if (mem_write) mem[mem_addr] <= mem_wdata;
        else if (pl_en) mem[pl_addr] <= pl_data;
    end

    function automatic logic [DATA_W-1:0] rand_word();
        logic [DATA_W-1:0] v;
        case ($urandom_range(0, 7))
            0: v = 16'h0000;
            1: v = 16'h0001;
            2: v = 16'hFFFF;
            3: v = 16'h0005;
            4: v = 16'hFFFD;
            5: v = 16'h8000;
            6: v = 16'h7FFF;
            default: v = 16'($urandom);
        endcase
        return v;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = rand_word();
    endtask

    task automatic sync_mem();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            pl_en = 1'b1; pl_addr = 6'(i); pl_data = ref_mem[i];
        end
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Reference: walk the lines with plain integer arithmetic, updating ref_mem
    task automatic model_scan(input int b, input int l);
        int a, w, prevw, writes;
        exp_neg = 0; exp_eq = 0; writes = 0; prevw = 0;
        exp_reads.delete();
        for (int i = 0; i < l; i++) begin
            a = (b + i) % DEPTH;
            exp_reads.push_back(a);
            w = int'($signed(ref_mem[a]));
            if (w < 0) exp_neg++;
            if (i > 0 && w == prevw) exp_eq++;
            prevw = w;
`ifdef LINE_SCAN_WRITEBACK_EN
            if (w < 0) begin
                writes++;
                ref_mem[a] = (w == -32768) ? 16'h7FFF : 16'(-w);
            end
`endif
        end
        exp_writes = writes;
        exp_done   = 1 + 2 * l + writes;
    endtask

    // Start a scan and record what the engine does until done or budget expiry
    task automatic run_scan(input int b, input int l, input int pulse_at);
        obs_done = -1; obs_writes = 0; obs_overlap = 0; obs_busy1 = 0;
        obs_reads.delete();
        @(negedge clk);
        start = 1'b1; base = ADDR_W'(b); len = CNT_W'(l);
        for (int c = 1; c <= BUDGET; c++) begin
            @(negedge clk);
            if (c == pulse_at) begin
                start = 1'b1; base = '0; len = '0;
            end else begin
                start = 1'b0;
            end
            if (c == 1) obs_busy1 = busy;
            if (mem_read) obs_reads.push_back(int'(mem_addr));
            if (mem_write) obs_writes++;
            if (mem_read && mem_write) obs_overlap = 1;
            if (done) begin
                obs_done = c;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, mem_read, mem_write} !== 4'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 0000", {busy, done, mem_read, mem_write});
        end
        checks++;
        if (neg_cnt !== '0 || eq_cnt !== '0) begin
            errors++;
            $display("FAIL reset_counts: got neg=%0d eq=%0d expected 0 0", neg_cnt, eq_cnt);
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_bus: got addr=%0d wdata=%h expected 0 0", mem_addr, mem_wdata);
        end
    endtask

    task automatic test_basic();
        fill_random();
        ref_mem[0] = 16'd5; ref_mem[1] = 16'hFFFD; ref_mem[2] = 16'hFFFD; ref_mem[3] = 16'd7;
        sync_mem();
        model_scan(0, 4);
        run_scan(0, 4, -1);
        checks++;
        if (obs_done !== exp_done) begin
            errors++;
            $display("FAIL basic_done: got cycle %0d expected %0d", obs_done, exp_done);
        end
        checks++;
        if (int'(neg_cnt) !== 2 || int'(eq_cnt) !== 1) begin
            errors++;
            $display("FAIL basic_counts: got neg=%0d eq=%0d expected 2 1", neg_cnt, eq_cnt);
        end
        checks++;
        if (obs_writes !== exp_writes || !obs_busy1) begin
            errors++;
            $display("FAIL basic_writes_busy: got writes=%0d busy1=%0d expected %0d 1", obs_writes, obs_busy1, exp_writes);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || int'(neg_cnt) !== 2) begin
            errors++;
            $display("FAIL basic_hold: got busy=%0d neg=%0d expected 0 2", busy, neg_cnt);
        end
    endtask

    task automatic test_empty();
        model_scan(5, 0);
        run_scan(5, 0, -1);
        checks++;
        if (obs_done !== 1) begin
            errors++;
            $display("FAIL empty_done: got cycle %0d expected 1", obs_done);
        end
        checks++;
        if (neg_cnt !== '0 || eq_cnt !== '0 || obs_reads.size() != 0 || obs_writes != 0) begin
            errors++;
            $display("FAIL empty_counts: got neg=%0d eq=%0d reads=%0d writes=%0d expected 0 0 0 0",
                     neg_cnt, eq_cnt, obs_reads.size(), obs_writes);
        end
    endtask

    task automatic test_wrap();
        int want[4] = '{62, 63, 0, 1};
        bit ok;
        fill_random();
        sync_mem();
        model_scan(62, 4);
        run_scan(62, 4, -1);
        ok = (obs_reads.size() == 4);
        for (int i = 0; i < 4 && ok; i++) if (obs_reads[i] != want[i]) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wrap_addrs: got %p expected %p", obs_reads, want);
        end
        checks++;
        if (int'(neg_cnt) !== exp_neg || int'(eq_cnt) !== exp_eq || obs_done !== exp_done) begin
            errors++;
            $display("FAIL wrap_result: got neg=%0d eq=%0d done=%0d expected %0d %0d %0d",
                     neg_cnt, eq_cnt, obs_done, exp_neg, exp_eq, exp_done);
        end
    endtask

    task automatic test_writeback();
        fill_random();
        ref_mem[20] = 16'hFFFB; ref_mem[21] = 16'h8000; ref_mem[22] = 16'd2;
        sync_mem();
        model_scan(20, 3);
        run_scan(20, 3, -1);
        @(negedge clk);
        checks++;
        if (int'(neg_cnt) !== 2 || obs_done !== exp_done) begin
            errors++;
            $display("FAIL wb_result: got neg=%0d done=%0d expected 2 %0d", neg_cnt, obs_done, exp_done);
        end
        checks++;
        if (mem[20] !== ref_mem[20] || mem[21] !== ref_mem[21] || mem[22] !== ref_mem[22]) begin
            errors++;
            $display("FAIL wb_memory: got %h %h %h expected %h %h %h",
                     mem[20], mem[21], mem[22], ref_mem[20], ref_mem[21], ref_mem[22]);
        end
    endtask

    task automatic test_busy_start();
        fill_random();
        sync_mem();
        model_scan(10, 8);
        run_scan(10, 8, 3);
        checks++;
        if (obs_done !== exp_done || int'(neg_cnt) !== exp_neg || int'(eq_cnt) !== exp_eq) begin
            errors++;
            $display("FAIL busy_start_ignored: got done=%0d neg=%0d eq=%0d expected %0d %0d %0d",
                     obs_done, neg_cnt, eq_cnt, exp_done, exp_neg, exp_eq);
        end
    endtask

    task automatic test_mid_reset();
        fill_random();
        sync_mem();
        @(negedge clk);
        start = 1'b1; base = 6'd0; len = 7'd40;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, mem_read, mem_write} !== 4'b0 || neg_cnt !== '0 || eq_cnt !== '0
            || mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got busy=%0d done=%0d rd=%0d wr=%0d neg=%0d eq=%0d addr=%0d expected all 0",
                     busy, done, mem_read, mem_write, neg_cnt, eq_cnt, mem_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = mem[i];
        model_scan(3, 5);
        run_scan(3, 5, -1);
        checks++;
        if (obs_done !== exp_done || int'(neg_cnt) !== exp_neg || int'(eq_cnt) !== exp_eq) begin
            errors++;
            $display("FAIL after_reset_scan: got done=%0d neg=%0d eq=%0d expected %0d %0d %0d",
                     obs_done, neg_cnt, eq_cnt, exp_done, exp_neg, exp_eq);
        end
    endtask

    task automatic test_random();
        int b, l;
        bit ok;
        for (int n = 0; n < 8; n++) begin
            fill_random();
            sync_mem();
            b = int'($urandom_range(0, DEPTH - 1));
            l = (n == 0) ? DEPTH : int'($urandom_range(1, DEPTH));
            model_scan(b, l);
            run_scan(b, l, -1);
            @(negedge clk);
            checks++;
            if (obs_done !== exp_done || int'(neg_cnt) !== exp_neg || int'(eq_cnt) !== exp_eq
                || obs_writes !== exp_writes || obs_overlap) begin
                errors++;
                $display("FAIL rand%0d_result: got done=%0d neg=%0d eq=%0d wr=%0d ovl=%0d expected %0d %0d %0d %0d 0",
                         n, obs_done, neg_cnt, eq_cnt, obs_writes, obs_overlap,
                         exp_done, exp_neg, exp_eq, exp_writes);
            end
            ok = (obs_reads.size() == exp_reads.size());
            for (int i = 0; i < exp_reads.size() && ok; i++) if (obs_reads[i] != exp_reads[i]) ok = 0;
            for (int i = 0; i < DEPTH && ok; i++) if (mem[i] !== ref_mem[i]) ok = 0;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL rand%0d_addrs_mem: got %0d reads expected %0d (or memory differs)",
                         n, obs_reads.size(), exp_reads.size());
            end
        end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; start = 1'b0; base = '0; len = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_basic();
        test_empty();
        test_wrap();
        test_writeback();
        test_busy_start();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
